// File: rtl/cyclotron_lane_buf_pkg.sv
// ---------------------------------------------------------------------------
// cyclotron_lane_buf_pkg
// Shared widths, request record layout and field offsets for the Cyclotron
// per-lane request buffer. Each request is packed MSB-first as
// {store, address, size, tag, data, mask}.
// The width helpers take the data/tag/address widths so a parametrised
// instance can derive its own packing. The struct and offsets describe the
// default 32-bit lane configuration.
// ---------------------------------------------------------------------------
package cyclotron_lane_buf_pkg;

   // Width of the size field: log2 of the byte count, enough bits to hold 0..log2(bytes)
   function automatic int szWidth(input int dataBits);
      return $clog2($clog2(dataBits / 8) + 1);
   endfunction

   // One byte-mask bit per data byte
   function automatic int mkWidth(input int dataBits);
      return dataBits / 8;
   endfunction

   // Total packed request width
   function automatic int reqWidth(input int archLen, input int dataBits, input int tagBits);
      return 1 + archLen + szWidth(dataBits) + tagBits + dataBits + mkWidth(dataBits);
   endfunction

   localparam int DEF_ARCH_LEN  = 32;
   localparam int DEF_DATA_BITS = 32;
   localparam int DEF_TAG_BITS  = 32;
   localparam int DEF_SZ        = szWidth(DEF_DATA_BITS);
   localparam int DEF_MK        = mkWidth(DEF_DATA_BITS);
   localparam int DEF_REQ_W     = reqWidth(DEF_ARCH_LEN, DEF_DATA_BITS, DEF_TAG_BITS);

   typedef struct packed {
      logic                     store;
      logic [DEF_ARCH_LEN-1:0]  address;
      logic [DEF_SZ-1:0]        size;
      logic [DEF_TAG_BITS-1:0]  tag;
      logic [DEF_DATA_BITS-1:0] data;
      logic [DEF_MK-1:0]        mask;
   } lane_req_t;

   // Bit positions of each field inside the default packed request
   localparam int MASK_LSB  = 0;
   localparam int DATA_LSB  = MASK_LSB + DEF_MK;
   localparam int TAG_LSB   = DATA_LSB + DEF_DATA_BITS;
   localparam int SIZE_LSB  = TAG_LSB + DEF_TAG_BITS;
   localparam int ADDR_LSB  = SIZE_LSB + DEF_SZ;
   localparam int STORE_BIT = ADDR_LSB + DEF_ARCH_LEN;

endpackage

// File: rtl/cyclotron_lane_fifo.sv
// ---------------------------------------------------------------------------
// cyclotron_lane_fifo
// Single-lane synchronous FIFO used to queue model requests for one lane.
// There is no write-through and no bypass. A push while full is dropped even
// if a pop happens in the same cycle. A push into an empty FIFO becomes
// visible on popData_o only in the following cycle.
// Ports:
//   clock, reset    : clock, synchronous active-high reset (empties the FIFO)
//   push_i          : write request, ignored while full
//   pushData_i      : write data
//   pop_i           : read request, ignored while empty
//   popData_o       : head entry
//   full_o, empty_o : occupancy flags
// ---------------------------------------------------------------------------
module cyclotron_lane_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] pushData_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] popData_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so that full and empty can be told apart
   logic [AW:0]      wrPtr_q, wrPtr_d;
   logic [AW:0]      rdPtr_q, rdPtr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             pushOk;
   logic             popOk;

   assign empty_o   = (wrPtr_q == rdPtr_q);
   assign full_o    = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign pushOk    = push_i && !full_o;
   assign popOk     = pop_i && !empty_o;
   assign popData_o = mem_q[rdPtr_q[AW-1:0]];

   // Next pointer values advance only on accepted operations
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      if (pushOk) wrPtr_d = wrPtr_q + (AW+1)'(1);
      if (popOk)  rdPtr_d = rdPtr_q + (AW+1)'(1);
   end

   // Pointer registers. Reset empties the FIFO.
   always_ff @(posedge clock) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
      end
   end

   // Storage needs no reset because the pointers decide which entries are live
   always_ff @(posedge clock) begin
      if (pushOk) mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
   end

endmodule

// File: rtl/cyclotron_lane_req_buffer.sv
// ---------------------------------------------------------------------------
// cyclotron_lane_req_buffer
// Per-lane decoupling buffer between the tick-driven Cyclotron tile model and
// the dmem fabric. Each lane is independent and has:
//   - a request FIFO,
//   - an in-flight counter that limits outstanding requests,
//   - a one-entry registered response stage.
// A drain-qualified 'finished' flag follows the model's end-of-program report.
// Ports:
//   clock, reset                  : clock, synchronous active-high reset
//   up_req_valid/ready/bits       : model -> buffer requests, per lane
//   dmem_req_valid/ready/bits     : buffer -> fabric requests, per lane
//   dmem_resp_valid/ready/bits_*  : fabric -> buffer responses, per lane
//   up_resp_valid/ready/bits_*    : buffer -> model responses, per lane
//   model_finished                : model reports program end (latched)
//   finished                      : model finished and every lane drained
//   busy                          : some lane holds queued, in-flight or staged work
//   err                           : sticky protocol error
// Optional feature macro: CYCLOTRON_LANE_BUF_CHECK_EN. When it is defined,
// err flags response underflow and requests issued after model_finished.
// When it is undefined, err is tied low.
// ---------------------------------------------------------------------------
module cyclotron_lane_req_buffer
   import cyclotron_lane_buf_pkg::*;
#(
   parameter int NUM_LANES      = 16,
   parameter int ARCH_LEN       = 32,
   parameter int DMEM_DATA_BITS = 32,
   parameter int DMEM_TAG_BITS  = 32,
   parameter int REQ_DEPTH      = 4,
   parameter int MAX_INFLIGHT   = 8
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [NUM_LANES-1:0]                up_req_valid,
   output logic [NUM_LANES-1:0]                up_req_ready,
   input  logic [NUM_LANES*(1+ARCH_LEN+szWidth(DMEM_DATA_BITS)+DMEM_TAG_BITS+DMEM_DATA_BITS+mkWidth(DMEM_DATA_BITS))-1:0] up_req_bits,
   output logic [NUM_LANES-1:0]                dmem_req_valid,
   input  logic [NUM_LANES-1:0]                dmem_req_ready,
   output logic [NUM_LANES*(1+ARCH_LEN+szWidth(DMEM_DATA_BITS)+DMEM_TAG_BITS+DMEM_DATA_BITS+mkWidth(DMEM_DATA_BITS))-1:0] dmem_req_bits,
   input  logic [NUM_LANES-1:0]                dmem_resp_valid,
   output logic [NUM_LANES-1:0]                dmem_resp_ready,
   input  logic [NUM_LANES*DMEM_TAG_BITS-1:0]  dmem_resp_bits_tag,
   input  logic [NUM_LANES*DMEM_DATA_BITS-1:0] dmem_resp_bits_data,
   output logic [NUM_LANES-1:0]                up_resp_valid,
   input  logic [NUM_LANES-1:0]                up_resp_ready,
   output logic [NUM_LANES*DMEM_TAG_BITS-1:0]  up_resp_bits_tag,
   output logic [NUM_LANES*DMEM_DATA_BITS-1:0] up_resp_bits_data,
   input  logic                                model_finished,
   output logic                                finished,
   output logic                                busy,
   output logic                                err
);

   localparam int SZ    = szWidth(DMEM_DATA_BITS);
   localparam int MK    = mkWidth(DMEM_DATA_BITS);
   localparam int REQ_W = 1 + ARCH_LEN + SZ + DMEM_TAG_BITS + DMEM_DATA_BITS + MK;
   localparam int IW    = $clog2(MAX_INFLIGHT + 1);
   localparam logic [IW-1:0] MAX_CNT = IW'(MAX_INFLIGHT);

   logic [NUM_LANES-1:0] laneBusy;
   logic                 doneSeen_q;
   logic                 finished_q;

`ifdef CYCLOTRON_LANE_BUF_CHECK_EN
   logic [NUM_LANES-1:0] underflow;
`endif

   genvar g;
   for (g = 0; g < NUM_LANES; g++) begin : gLane
      logic                      fifoFull;
      logic                      fifoEmpty;
      logic [REQ_W-1:0]          fifoHead;
      logic                      reqFire;
      logic                      respFire;
      logic                      upFire;
      logic [IW-1:0]             inflight_q, inflight_d;
      logic                      stageValid_q, stageValid_d;
      logic [DMEM_TAG_BITS-1:0]  stageTag_q;
      logic [DMEM_DATA_BITS-1:0] stageData_q;

      // Every handshake output is forced low while reset is held
      assign up_req_ready[g]    = !reset && !fifoFull;
      assign dmem_req_valid[g]  = !reset && !fifoEmpty && (inflight_q < MAX_CNT);
      assign dmem_resp_ready[g] = !reset && (!stageValid_q || up_resp_ready[g]);
      assign up_resp_valid[g]   = !reset && stageValid_q;

      assign reqFire  = dmem_req_valid[g] && dmem_req_ready[g];
      assign respFire = dmem_resp_valid[g] && dmem_resp_ready[g];
      assign upFire   = up_resp_valid[g] && up_resp_ready[g];

      assign dmem_req_bits[REQ_W*g +: REQ_W]                    = fifoHead;
      assign up_resp_bits_tag[DMEM_TAG_BITS*g +: DMEM_TAG_BITS]   = stageTag_q;
      assign up_resp_bits_data[DMEM_DATA_BITS*g +: DMEM_DATA_BITS] = stageData_q;

      assign laneBusy[g] = !fifoEmpty || (inflight_q != '0) || stageValid_q;

      cyclotron_lane_fifo #(
         .WIDTH (REQ_W),
         .DEPTH (REQ_DEPTH)
      ) uFifo (
         .clock      (clock),
         .reset      (reset),
         .push_i     (up_req_valid[g] && up_req_ready[g]),
         .pushData_i (up_req_bits[REQ_W*g +: REQ_W]),
         .pop_i      (reqFire),
         .popData_o  (fifoHead),
         .full_o     (fifoFull),
         .empty_o    (fifoEmpty)
      );

      // A fire and a response in the same cycle cancel each other out.
      // A stray response at zero saturates instead of wrapping.
      always_comb begin
         inflight_d = inflight_q;
         if (reqFire && !respFire)
            inflight_d = inflight_q + IW'(1);
         else if (!reqFire && respFire && (inflight_q != '0))
            inflight_d = inflight_q - IW'(1);
      end

      // Loading takes priority over draining, so a simultaneous drain and
      // load keeps the stage full and holds the new response
      always_comb begin
         stageValid_d = stageValid_q;
         if (respFire)    stageValid_d = 1'b1;
         else if (upFire) stageValid_d = 1'b0;
      end

      // Lane state registers. Payload registers only load on accept.
      always_ff @(posedge clock) begin
         if (reset) begin
            inflight_q   <= '0;
            stageValid_q <= 1'b0;
         end else begin
            inflight_q   <= inflight_d;
            stageValid_q <= stageValid_d;
         end
         if (respFire) begin
            stageTag_q  <= dmem_resp_bits_tag[DMEM_TAG_BITS*g +: DMEM_TAG_BITS];
            stageData_q <= dmem_resp_bits_data[DMEM_DATA_BITS*g +: DMEM_DATA_BITS];
         end
      end

`ifdef CYCLOTRON_LANE_BUF_CHECK_EN
      assign underflow[g] = respFire && (inflight_q == '0);

      // Name the offending lane when a protocol error is detected
      always_ff @(posedge clock) begin
         if (!reset && underflow[g])
            $error("cyclotron_lane_req_buffer: response underflow on lane %0d", g);
         if (!reset && doneSeen_q && up_req_valid[g])
            $error("cyclotron_lane_req_buffer: request on lane %0d after model finished", g);
      end
`endif
   end

   assign busy     = |laneBusy;
   assign finished = finished_q;

   // done_seen latches the model's end report. finished rises one cycle after
   // every lane is empty, then holds until reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         doneSeen_q <= 1'b0;
         finished_q <= 1'b0;
      end else begin
         doneSeen_q <= doneSeen_q | model_finished;
         finished_q <= finished_q | (doneSeen_q && !busy);
      end
   end

`ifdef CYCLOTRON_LANE_BUF_CHECK_EN
   logic err_q, err_d;

   // Sticky error: set by any lane underflow or by a request after done_seen
   always_comb begin
      err_d = err_q | (|underflow) | (doneSeen_q && (|up_req_valid));
   end

   always_ff @(posedge clock) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cyclotron_lane_req_buffer.sv
// ---------------------------------------------------------------------------
// tb_cyclotron_lane_req_buffer
// Directed bench for the per-lane request buffer, built with MAX_INFLIGHT=2
// and REQ_DEPTH=4. The steps cover:
//   - reset state,
//   - FIFO fill and order,
//   - credit limiting,
//   - response staging,
//   - the finished/busy handshake,
//   - reset mid-operation,
//   - an all-lane random soak with a counter-based ordering model.
// ---------------------------------------------------------------------------
module tb_cyclotron_lane_req_buffer;
   import cyclotron_lane_buf_pkg::*;

   localparam int NL    = 16;
   localparam int DB    = 32;
   localparam int TBW   = 32;
   localparam int MI    = 2;
   localparam int REQ_W = reqWidth(32, DB, TBW);

   typedef logic [127:0] chk_t;

   logic                clock;
   logic                reset;
   logic [NL-1:0]       up_req_valid;
   logic [NL-1:0]       up_req_ready;
   logic [NL*REQ_W-1:0] up_req_bits;
   logic [NL-1:0]       dmem_req_valid;
   logic [NL-1:0]       dmem_req_ready;
   logic [NL*REQ_W-1:0] dmem_req_bits;
   logic [NL-1:0]       dmem_resp_valid;
   logic [NL-1:0]       dmem_resp_ready;
   logic [NL*TBW-1:0]   dmem_resp_bits_tag;
   logic [NL*DB-1:0]    dmem_resp_bits_data;
   logic [NL-1:0]       up_resp_valid;
   logic [NL-1:0]       up_resp_ready;
   logic [NL*TBW-1:0]   up_resp_bits_tag;
   logic [NL*DB-1:0]    up_resp_bits_data;
   logic                model_finished;
   logic                finished;
   logic                busy;
   logic                err;

   int testsRun    = 0;
   int testsFailed = 0;

   int accCnt  [NL];
   int fireCnt [NL];
   int respCnt [NL];
   int upCnt   [NL];
   int ordErr  [NL];

   cyclotron_lane_req_buffer #(
      .NUM_LANES      (NL),
      .ARCH_LEN       (32),
      .DMEM_DATA_BITS (DB),
      .DMEM_TAG_BITS  (TBW),
      .REQ_DEPTH      (4),
      .MAX_INFLIGHT   (MI)
   ) dut (
      .clock               (clock),
      .reset               (reset),
      .up_req_valid        (up_req_valid),
      .up_req_ready        (up_req_ready),
      .up_req_bits         (up_req_bits),
      .dmem_req_valid      (dmem_req_valid),
      .dmem_req_ready      (dmem_req_ready),
      .dmem_req_bits       (dmem_req_bits),
      .dmem_resp_valid     (dmem_resp_valid),
      .dmem_resp_ready     (dmem_resp_ready),
      .dmem_resp_bits_tag  (dmem_resp_bits_tag),
      .dmem_resp_bits_data (dmem_resp_bits_data),
      .up_resp_valid       (up_resp_valid),
      .up_resp_ready       (up_resp_ready),
      .up_resp_bits_tag    (up_resp_bits_tag),
      .up_resp_bits_data   (up_resp_bits_data),
      .model_finished      (model_finished),
      .finished            (finished),
      .busy                (busy),
      .err                 (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Build a packed request from an address and tag. The other fields are
   // derived so that any corruption of the payload shows up.
   function automatic logic [REQ_W-1:0] mkReq(input logic [31:0] addr, input logic [31:0] tag);
      lane_req_t r;
      r.store   = addr[2];
      r.address = addr;
      r.size    = 2'd2;
      r.tag     = tag;
      r.data    = ~tag;
      r.mask    = 4'hF;
      return r;
   endfunction

   function automatic logic [31:0] stressTag(input int lane, input int seq);
      return {16'(lane), 16'(seq)};
   endfunction

   function automatic logic [31:0] stressData(input int seq);
      return 32'hA500_0000 ^ 32'(seq);
   endfunction

   function automatic logic [REQ_W-1:0] stressReq(input int lane, input int seq);
      return mkReq(32'(seq) << 2, stressTag(lane, seq));
   endfunction

   function automatic logic [REQ_W-1:0] dmemBits(input int lane);
      return dmem_req_bits[REQ_W*lane +: REQ_W];
   endfunction

   function automatic logic [TBW-1:0] upTag(input int lane);
      return up_resp_bits_tag[TBW*lane +: TBW];
   endfunction

   function automatic logic [DB-1:0] upData(input int lane);
      return up_resp_bits_data[DB*lane +: DB];
   endfunction

   // Advance n clock edges and land 1 time unit after the last one
   task automatic applyStimulus(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic setReq(input int lane, input logic [REQ_W-1:0] val);
      up_req_bits[REQ_W*lane +: REQ_W] = val;
   endtask

   task automatic setResp(input int lane, input logic [31:0] tag, input logic [31:0] data);
      dmem_resp_bits_tag[TBW*lane +: TBW] = tag;
      dmem_resp_bits_data[DB*lane +: DB]  = data;
   endtask

   task automatic checkOutput(input string tag, input chk_t observed, input chk_t expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      logic expErr;
`ifdef CYCLOTRON_LANE_BUF_CHECK_EN
      expErr = 1'b1;
`else
      expErr = 1'b0;
`endif
      reset               = 1'b1;
      up_req_valid        = '0;
      up_req_bits         = '0;
      dmem_req_ready      = '0;
      dmem_resp_valid     = '0;
      dmem_resp_bits_tag  = '0;
      dmem_resp_bits_data = '0;
      up_resp_ready       = '0;
      model_finished      = 1'b0;
      for (int i = 0; i < NL; i++) begin
         accCnt[i] = 0; fireCnt[i] = 0; respCnt[i] = 0; upCnt[i] = 0; ordErr[i] = 0;
      end

      // ---- Reset state ----
      applyStimulus(2);
      checkOutput("rstHeldUpReady", chk_t'(up_req_ready), chk_t'(0));
      checkOutput("rstHeldRespReady", chk_t'(dmem_resp_ready), chk_t'(0));
      reset = 1'b0;
      #1;
      checkOutput("rstUpReady", chk_t'(up_req_ready), chk_t'(16'hFFFF));
      checkOutput("rstDmemValid", chk_t'(dmem_req_valid), chk_t'(0));
      checkOutput("rstUpRespValid", chk_t'(up_resp_valid), chk_t'(0));
      checkOutput("rstBusy", chk_t'(busy), chk_t'(0));
      checkOutput("rstFinished", chk_t'(finished), chk_t'(0));
      checkOutput("rstErr", chk_t'(err), chk_t'(0));

      // ---- Lane 0: fill the FIFO, then drain it under the credit limit ----
      for (int i = 0; i < 4; i++) begin
         up_req_valid[0] = 1'b1;
         setReq(0, mkReq(32'h100 + 32'(4*i), 32'h10 + 32'(i)));
         #1;
         checkOutput("fillReady", chk_t'(up_req_ready[0]), chk_t'(1));
         applyStimulus(1);
      end
      checkOutput("fullReady", chk_t'(up_req_ready[0]), chk_t'(0));
      checkOutput("headValid", chk_t'(dmem_req_valid[0]), chk_t'(1));
      checkOutput("headBits0", chk_t'(dmemBits(0)), chk_t'(mkReq(32'h100, 32'h10)));
      setReq(0, mkReq(32'h200, 32'h99));
      applyStimulus(1);
      up_req_valid[0] = 1'b0;
      #1;
      checkOutput("fifthRejected", chk_t'(up_req_ready[0]), chk_t'(0));
      dmem_req_ready[0] = 1'b1;
      applyStimulus(1);
      checkOutput("fire1Bits", chk_t'(dmemBits(0)), chk_t'(mkReq(32'h104, 32'h11)));
      applyStimulus(1);
      checkOutput("creditStall", chk_t'(dmem_req_valid[0]), chk_t'(0));
      checkOutput("creditUpReady", chk_t'(up_req_ready[0]), chk_t'(1));
      applyStimulus(1);
      checkOutput("creditStallHold", chk_t'(dmem_req_valid[0]), chk_t'(0));
      dmem_resp_valid[0] = 1'b1;
      setResp(0, 32'h5, 32'h1111_0005);
      up_resp_ready[0] = 1'b1;
      #1;
      checkOutput("respReady0", chk_t'(dmem_resp_ready[0]), chk_t'(1));
      applyStimulus(1);
      dmem_resp_valid[0] = 1'b0;
      #1;
      checkOutput("thirdValid", chk_t'(dmem_req_valid[0]), chk_t'(1));
      checkOutput("thirdBits", chk_t'(dmemBits(0)), chk_t'(mkReq(32'h108, 32'h12)));
      checkOutput("resp5Valid", chk_t'(up_resp_valid[0]), chk_t'(1));
      checkOutput("resp5Tag", chk_t'(upTag(0)), chk_t'(32'h5));
      applyStimulus(1);
      checkOutput("creditStall2", chk_t'(dmem_req_valid[0]), chk_t'(0));
      checkOutput("resp5Drained", chk_t'(up_resp_valid[0]), chk_t'(0));
      dmem_resp_valid[0] = 1'b1;
      setResp(0, 32'h6, 32'h1111_0006);
      applyStimulus(1);
      setResp(0, 32'h7, 32'h1111_0007);
      #1;
      checkOutput("fourthBits", chk_t'(dmemBits(0)), chk_t'(mkReq(32'h10C, 32'h13)));
      applyStimulus(1);
      checkOutput("b2bTag7", chk_t'(upTag(0)), chk_t'(32'h7));
      checkOutput("fifoEmptyValid", chk_t'(dmem_req_valid[0]), chk_t'(0));
      setResp(0, 32'h8, 32'h1111_0008);
      applyStimulus(1);
      dmem_resp_valid[0] = 1'b0;
      #1;
      checkOutput("busyStaged", chk_t'(busy), chk_t'(1));
      applyStimulus(1);
      checkOutput("lane0Idle", chk_t'(busy), chk_t'(0));
      dmem_req_ready[0] = 1'b0;
      up_resp_ready[0]  = 1'b0;

      // ---- Lane 1: response staging with backpressure ----
      dmem_req_ready[1] = 1'b1;
      up_req_valid[1]   = 1'b1;
      setReq(1, mkReq(32'h300, 32'h20));
      applyStimulus(1);
      setReq(1, mkReq(32'h304, 32'h21));
      applyStimulus(1);
      up_req_valid[1] = 1'b0;
      applyStimulus(2);
      checkOutput("l1AllFired", chk_t'(dmem_req_valid[1]), chk_t'(0));
      checkOutput("l1Busy", chk_t'(busy), chk_t'(1));
      dmem_resp_valid[1] = 1'b1;
      setResp(1, 32'hA, 32'hDEAD_BEEF);
      applyStimulus(1);
      dmem_resp_valid[1] = 1'b0;
      #1;
      checkOutput("stageValid", chk_t'(up_resp_valid[1]), chk_t'(1));
      checkOutput("stageTag", chk_t'(upTag(1)), chk_t'(32'hA));
      checkOutput("stageData", chk_t'(upData(1)), chk_t'(32'hDEAD_BEEF));
      checkOutput("stageBackpress", chk_t'(dmem_resp_ready[1]), chk_t'(0));
      applyStimulus(1);
      checkOutput("stageHoldData", chk_t'(upData(1)), chk_t'(32'hDEAD_BEEF));
      up_resp_ready[1]   = 1'b1;
      dmem_resp_valid[1] = 1'b1;
      setResp(1, 32'hB, 32'hCAFE_F00D);
      #1;
      checkOutput("passThroughReady", chk_t'(dmem_resp_ready[1]), chk_t'(1));
      applyStimulus(1);
      dmem_resp_valid[1] = 1'b0;
      #1;
      checkOutput("b2bValid", chk_t'(up_resp_valid[1]), chk_t'(1));
      checkOutput("b2bTagB", chk_t'(upTag(1)), chk_t'(32'hB));
      checkOutput("b2bDataB", chk_t'(upData(1)), chk_t'(32'hCAFE_F00D));
      applyStimulus(1);
      checkOutput("l1Drained", chk_t'(up_resp_valid[1]), chk_t'(0));
      checkOutput("l1Idle", chk_t'(busy), chk_t'(0));
      dmem_req_ready[1] = 1'b0;
      up_resp_ready[1]  = 1'b0;

      // ---- All lanes: random soak, then drain ----
      for (int cyc = 0; cyc < 1060; cyc++) begin
         bit drain;
         drain = (cyc >= 1000);
         for (int g = 0; g < NL; g++) begin
            up_req_valid[g]    = !drain && ($urandom_range(0, 3) != 0);
            setReq(g, stressReq(g, accCnt[g]));
            dmem_req_ready[g]  = drain || ($urandom_range(0, 3) != 0);
            dmem_resp_valid[g] = (fireCnt[g] > respCnt[g]) && (drain || ($urandom_range(0, 2) != 0));
            setResp(g, stressTag(g, respCnt[g]), stressData(respCnt[g]));
            up_resp_ready[g]   = drain || ($urandom_range(0, 3) != 0);
         end
         #1;
         for (int g = 0; g < NL; g++) begin
            if (up_resp_valid[g] && up_resp_ready[g]) begin
               if (upTag(g) !== stressTag(g, upCnt[g]) || upData(g) !== stressData(upCnt[g]))
                  ordErr[g]++;
               upCnt[g]++;
            end
            if (dmem_resp_valid[g] && dmem_resp_ready[g]) respCnt[g]++;
            if (dmem_req_valid[g] && dmem_req_ready[g]) begin
               if (dmemBits(g) !== stressReq(g, fireCnt[g])) ordErr[g]++;
               fireCnt[g]++;
            end
            if (fireCnt[g] - respCnt[g] > MI) ordErr[g]++;
            if (up_req_valid[g] && up_req_ready[g]) accCnt[g]++;
         end
         applyStimulus(1);
      end
      up_req_valid    = '0;
      dmem_req_ready  = '0;
      dmem_resp_valid = '0;
      up_resp_ready   = '0;
      #1;
      for (int g = 0; g < NL; g++) begin
         checkOutput($sformatf("soakOrder%0d", g), chk_t'(ordErr[g]), chk_t'(0));
         checkOutput($sformatf("soakDelivered%0d", g), chk_t'(upCnt[g]), chk_t'(accCnt[g]));
      end
      checkOutput("soakProgress", chk_t'(accCnt[0] > 100), chk_t'(1));
      checkOutput("soakIdle", chk_t'(busy), chk_t'(0));

      // ---- Lane 3: finished waits for the last response to drain ----
      dmem_req_ready[3] = 1'b1;
      up_resp_ready[3]  = 1'b1;
      up_req_valid[3]   = 1'b1;
      setReq(3, mkReq(32'h400, 32'h30));
      applyStimulus(1);
      up_req_valid[3] = 1'b0;
      applyStimulus(1);
      model_finished = 1'b1;
      applyStimulus(1);
      model_finished = 1'b0;
      applyStimulus(3);
      checkOutput("finWaitInflight", chk_t'(finished), chk_t'(0));
      checkOutput("finBusy", chk_t'(busy), chk_t'(1));
      dmem_resp_valid[3] = 1'b1;
      setResp(3, 32'h30, 32'h0000_3030);
      applyStimulus(1);
      dmem_resp_valid[3] = 1'b0;
      #1;
      checkOutput("finWaitStage", chk_t'(finished), chk_t'(0));
      checkOutput("finStageValid", chk_t'(up_resp_valid[3]), chk_t'(1));
      applyStimulus(1);
      checkOutput("finDrainedBusy", chk_t'(busy), chk_t'(0));
      checkOutput("finNotYet", chk_t'(finished), chk_t'(0));
      applyStimulus(1);
      checkOutput("finSet", chk_t'(finished), chk_t'(1));
      applyStimulus(2);
      checkOutput("finHold", chk_t'(finished), chk_t'(1));
      dmem_req_ready[3] = 1'b0;
      up_resp_ready[3]  = 1'b0;

      // ---- Lane 2: reset discards queued work; a late response saturates ----
      for (int i = 0; i < 3; i++) begin
         up_req_valid[2] = 1'b1;
         setReq(2, mkReq(32'h500 + 32'(4*i), 32'h40 + 32'(i)));
         applyStimulus(1);
      end
      up_req_valid[2] = 1'b0;
      #1;
      checkOutput("l2Queued", chk_t'(dmem_req_valid[2]), chk_t'(1));
      reset = 1'b1;
      applyStimulus(1);
      checkOutput("rstMidReqValid", chk_t'(dmem_req_valid), chk_t'(0));
      checkOutput("rstMidUpReady", chk_t'(up_req_ready), chk_t'(0));
      checkOutput("rstMidRespReady", chk_t'(dmem_resp_ready), chk_t'(0));
      reset = 1'b0;
      dmem_req_ready[2] = 1'b1;
      #1;
      checkOutput("postRstEmpty", chk_t'(dmem_req_valid), chk_t'(0));
      checkOutput("postRstUpReady", chk_t'(up_req_ready), chk_t'(16'hFFFF));
      checkOutput("postRstBusy", chk_t'(busy), chk_t'(0));
      checkOutput("postRstFinished", chk_t'(finished), chk_t'(0));
      checkOutput("postRstErr", chk_t'(err), chk_t'(0));
      dmem_resp_valid[2] = 1'b1;
      setResp(2, 32'h77, 32'h7777_7777);
      applyStimulus(1);
      dmem_resp_valid[2] = 1'b0;
      #1;
      checkOutput("lateStaged", chk_t'(up_resp_valid[2]), chk_t'(1));
      checkOutput("lateErr", chk_t'(err), chk_t'(expErr));
      up_resp_ready[2] = 1'b1;
      applyStimulus(1);
      checkOutput("lateNoUnderflow", chk_t'(busy), chk_t'(0));
      checkOutput("lateNoFire", chk_t'(dmem_req_valid[2]), chk_t'(0));
      checkOutput("lateErrSticky", chk_t'(err), chk_t'(expErr));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
